regfile_op_sequencer: RTL and testbench
=======================================

// Module: regfile_op_sequencer
// PURPOSE
// - Multi-cycle controller that sequences RegisterFile control inputs (OutASel, OutBSel, FunSel, RegSel, ScrSel, I).
// - Accepts one register-level command at a time (MOVE, SWAP, CLEAR, INC) over a valid/ready handshake.
// - Expands each command into RF write steps; SWAP goes through a scratch temp register.
// - Sits between the control unit and the RegisterFile; RF OutA feeds back into RfOutA.
// PARAMETERS
// - FUN_DEC   3'b000  FunSel code: decrement
// - FUN_INC   3'b001  FunSel code: increment
// - FUN_LOAD  3'b010  FunSel code: load I
// - FUN_CLR   3'b011  FunSel code: clear
// - TMP_SEL   3'd7    register index used as SWAP temp (0-3 = R1-R4, 4-7 = S1-S4)
// PORTS
// - Clock      in   1   rising-edge clock
// - Reset      in   1   asynchronous, active-high reset
// - CmdValid   in   1   command present
// - CmdReady   out  1   sequencer can accept a command
// - CmdOp      in   2   00 MOVE dst<=src, 01 SWAP src<->dst, 10 CLEAR dst, 11 INC dst
// - CmdSrc     in   3   source index (same encoding as OutASel)
// - CmdDst     in   3   destination index
// - RfOutA     in   16  RegisterFile OutA
// - RfI        out  16  RegisterFile I
// - OutASel    out  3   to RF
// - OutBSel    out  3   to RF (debug view of the step's destination)
// - FunSel     out  3   to RF
// - RegSel     out  4   to RF, active-low per register; bit3=R1 .. bit0=R4
// - ScrSel     out  4   to RF, active-low per register; bit3=S1 .. bit0=S4
// - Done       out  1   one-cycle pulse: command finished
// - DoneErr    out  1   valid with Done; 1 = command rejected, no RF writes
// - PerfCount  out  16  completed-command counter (see CONFIGURATION)
// BEHAVIOUR
// - FSM states: IDLE, STEP1, STEP2, STEP3, DONE. Reset -> IDLE.
// - Reset values: CmdReady=1, Done=0, DoneErr=0, RegSel=ScrSel=4'b1111, FunSel=FUN_LOAD, OutASel=OutBSel=0, RfI=0, PerfCount=0.
// - CmdReady=1 only in IDLE. A command is accepted on the edge where CmdValid&CmdReady; CmdOp/CmdSrc/CmdDst are latched then.
// - Control outputs are Moore-decoded from state + latched fields. An RF write occurs at the clock edge ending each STEPn cycle.
// - Write target idx: idx 0-3 clears RegSel bit (3-idx); idx 4-7 clears ScrSel bit (7-idx). At most one enable low per step.
// - RfI = RfOutA (combinational pass-through) in STEP states with FUN_LOAD; 16'h0 otherwise.
// - MOVE:  STEP1 OutASel=src, FunSel=FUN_LOAD, write dst -> DONE. src==dst is legal (value unchanged).
// - CLEAR: STEP1 FunSel=FUN_CLR, write dst -> DONE. INC: STEP1 FunSel=FUN_INC, write dst -> DONE. CmdSrc ignored.
// - SWAP:  STEP1 TMP<=src; STEP2 src<=dst; STEP3 dst<=TMP; -> DONE.
// - SWAP with src==dst: IDLE -> DONE, no writes, DoneErr=0.
// - SWAP with src==TMP_SEL or dst==TMP_SEL: IDLE -> DONE, no writes, DoneErr=1.
// - Latency accept edge -> Done high: MOVE/CLEAR/INC 2 cycles; SWAP 4 cycles; degenerate/rejected SWAP 1 cycle.
// - DONE: Done=1 for exactly one cycle, all enables high; next state IDLE. Back-to-back commands: next accept one cycle after DONE.
// - OutBSel = the current step's write target in STEP states; 0 in IDLE and DONE.
// - CmdValid while busy is ignored (no queueing); requester must hold until CmdReady.
// - Reset mid-operation: immediate return to IDLE, all enables deasserted asynchronously. Completed steps are not rolled back; a partial SWAP may leave TMP/src modified.
// CONFIGURATION
// - Macro REGSEQ_PERF_EN defined: PerfCount increments on every Done with DoneErr=0; wraps 16'hFFFF -> 16'h0000; cleared by Reset.
// - REGSEQ_PERF_EN undefined: no counter logic; PerfCount tied to 16'h0000.
// TESTING
// - Reset then MOVE src=0 dst=2, R1=16'h1234 -> R3=16'h1234 after 2 cycles, Done pulse, RegSel=4'b1101 during STEP1.
// - SWAP src=1 dst=4, R2=16'hAAAA, S1=16'h5555 -> R2=16'h5555, S1=16'hAAAA, S4=16'hAAAA, Done 4 cycles after accept.
// - SWAP src=3 dst=7 -> Done with DoneErr=1 after 1 cycle, no enables low, all registers unchanged.
// - INC dst=5 with S2=16'hFFFF -> S2=16'h0000; CLEAR dst=0 -> R1=16'h0000; CmdReady low until DONE is left.
// - Assert Reset during STEP2 of a SWAP -> RegSel=ScrSel=4'b1111 the same cycle, CmdReady=1, Done never pulses for that command.
// - With REGSEQ_PERF_EN: 3 good commands + 1 rejected -> PerfCount=3; without macro PerfCount stays 16'h0000.

Source files
------------

// File: rtl/regfile_op_sequencer_if.sv
// Command handshake and RegisterFile control bundle for regfile_op_sequencer.
// master: control unit / RF side; slave: the sequencer.
interface regfile_op_sequencer_if;
  logic        CmdValid;
  logic        CmdReady;
  logic [1:0]  CmdOp;
  logic [2:0]  CmdSrc;
  logic [2:0]  CmdDst;
  logic [15:0] RfOutA;
  logic [15:0] RfI;
  logic [2:0]  OutASel;
  logic [2:0]  OutBSel;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel;
  logic [3:0]  ScrSel;
  logic        Done;
  logic        DoneErr;
  logic [15:0] PerfCount;

  modport master (
    output CmdValid, CmdOp, CmdSrc, CmdDst, RfOutA,
    input  CmdReady, RfI, OutASel, OutBSel, FunSel,
    input  RegSel, ScrSel, Done, DoneErr, PerfCount
  );

  modport slave (
    input  CmdValid, CmdOp, CmdSrc, CmdDst, RfOutA,
    output CmdReady, RfI, OutASel, OutBSel, FunSel,
    output RegSel, ScrSel, Done, DoneErr, PerfCount
  );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Sequences RegisterFile writes for MOVE/SWAP/CLEAR/INC commands.
// Ports: clk, rst (async, active-high), bus (slave: command handshake,
// RF selects/FunSel/I, Done/DoneErr, PerfCount).
// Optional macro REGSEQ_PERF_EN enables the completed-command counter.
module regfile_op_sequencer #(
  parameter logic [2:0] FUN_DEC  = 3'b000,
  parameter logic [2:0] FUN_INC  = 3'b001,
  parameter logic [2:0] FUN_LOAD = 3'b010,
  parameter logic [2:0] FUN_CLR  = 3'b011,
  parameter logic [2:0] TMP_SEL  = 3'd7
) (
  input logic                   clk,
  input logic                   rst,
  regfile_op_sequencer_if.slave bus
);
  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_SWAP = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_INC  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, STEP1, STEP2, STEP3, DONE
  } state_t;

  state_t     state, state_nx;
  logic [1:0] op_q;
  logic [2:0] src_q, dst_q;
  logic       err_q;
  logic       accept, rej, degen, is_swap;
  logic       wr;
  logic [2:0] tgt, asel, fun;
  logic [3:0] reg_sel, scr_sel;

  assign is_swap = bus.CmdOp == OP_SWAP;
  // Rejection wins over the src==dst shortcut when both apply.
  assign rej    = is_swap &&
                  (bus.CmdSrc == TMP_SEL || bus.CmdDst == TMP_SEL);
  assign degen  = is_swap && bus.CmdSrc == bus.CmdDst;
  assign accept = bus.CmdValid && state == IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= OP_MOVE;
      src_q <= '0;
      dst_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= bus.CmdOp;
        src_q <= bus.CmdSrc;
        dst_q <= bus.CmdDst;
        err_q <= rej;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.CmdValid)
               state_nx = (rej || degen) ? DONE : STEP1;
      STEP1: state_nx = (op_q == OP_SWAP) ? STEP2 : DONE;
      STEP2: state_nx = STEP3;
      STEP3: state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore decode of the current step's write.
  always_comb begin
    wr   = 1'b0;
    tgt  = '0;
    asel = '0;
    fun  = FUN_LOAD;
    unique case (state)
      STEP1: begin
        wr   = 1'b1;
        asel = src_q;
        tgt  = (op_q == OP_SWAP) ? TMP_SEL : dst_q;
        unique case (op_q)
          OP_CLR:  fun = FUN_CLR;
          OP_INC:  fun = FUN_INC;
          default: fun = FUN_LOAD;
        endcase
      end
      STEP2: begin
        wr   = 1'b1;
        asel = dst_q;
        tgt  = src_q;
      end
      STEP3: begin
        wr   = 1'b1;
        asel = TMP_SEL;
        tgt  = dst_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    reg_sel = 4'b1111;
    scr_sel = 4'b1111;
    if (wr) begin
      if (!tgt[2]) reg_sel[2'd3 - tgt[1:0]] = 1'b0;
      else         scr_sel[2'd3 - tgt[1:0]] = 1'b0;
    end
  end

  assign bus.CmdReady = state == IDLE;
  assign bus.Done     = state == DONE;
  assign bus.DoneErr  = state == DONE && err_q;
  assign bus.OutASel  = asel;
  assign bus.OutBSel  = tgt;
  assign bus.FunSel   = fun;
  assign bus.RegSel   = reg_sel;
  assign bus.ScrSel   = scr_sel;
  assign bus.RfI      = (wr && fun == FUN_LOAD) ? bus.RfOutA : 16'h0;

`ifdef REGSEQ_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_q <= '0;
    else if (state == DONE && !err_q)
      perf_q <= perf_q + 16'd1;
  end
  assign bus.PerfCount = perf_q;
`else
  assign bus.PerfCount = 16'h0000;
`endif

  logic unused_ok;
  assign unused_ok = ^{FUN_DEC, OP_MOVE};
endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench for regfile_op_sequencer with a behavioural RF.
// Expected register images are queued at issue, checked on Done.
module tb_regfile_op_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_op_sequencer_if bus();
  regfile_op_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic         err;
    int           lat;
    logic [127:0] regs;
    int           acc;
  } sb_t;

  sb_t         q[$];
  sb_t         e;
  logic [15:0] rf[8];
  logic [15:0] sh[8];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          bad_en = 0;
  int          good = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack_rf(input logic [15:0] r[8]);
    return {r[7], r[6], r[5], r[4], r[3], r[2], r[1], r[0]};
  endfunction

  function automatic logic [15:0] rf_op(input logic [2:0] f,
                                        input logic [15:0] v,
                                        input logic [15:0] i);
    case (f)
      3'b000:  return v - 16'd1;
      3'b001:  return v + 16'd1;
      3'b010:  return i;
      3'b011:  return 16'h0;
      default: return v;
    endcase
  endfunction

  assign bus.RfOutA = rf[bus.OutASel];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++)
      if (!bus.RegSel[3-i])
        rf[i] <= rf_op(bus.FunSel, rf[i], bus.RfI);
    for (int i = 0; i < 4; i++)
      if (!bus.ScrSel[3-i])
        rf[i+4] <= rf_op(bus.FunSel, rf[i+4], bus.RfI);
  end

  always @(negedge clk) begin
    if ($countones(~{bus.RegSel, bus.ScrSel}) > 1) bad_en++;
    if (!rst && bus.Done) begin
      if (q.size() == 0) begin
        chk("spurious_done", {127'd0, bus.Done}, 128'd0);
      end else begin
        e = q.pop_front();
        chk("done_err", {127'd0, bus.DoneErr}, {127'd0, e.err});
        chk("latency", 128'(cyc - e.acc + 1), 128'(e.lat));
        chk("regs", pack_rf(rf), e.regs);
      end
    end
  end

  task automatic preload(input int idx, input logic [15:0] v);
    rf[idx] = v;
    sh[idx] = v;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] src,
                       input logic [2:0] dst);
    sb_t         n;
    logic        dg;
    logic [15:0] t;
    int          k;
    n.err = (op == 2'b01) && (src == 3'd7 || dst == 3'd7);
    dg    = (op == 2'b01) && (src == dst);
    n.lat = (n.err || dg) ? 1 : (op == 2'b01) ? 4 : 2;
    if (!n.err) begin
      case (op)
        2'b00: sh[dst] = sh[src];
        2'b01: if (!dg) begin
          t = sh[src];
          sh[7] = t;
          sh[src] = sh[dst];
          sh[dst] = t;
        end
        2'b10: sh[dst] = 16'h0;
        default: sh[dst] = sh[dst] + 16'd1;
      endcase
    end
    @(negedge clk);
    bus.CmdValid = 1'b1;
    bus.CmdOp = op;
    bus.CmdSrc = src;
    bus.CmdDst = dst;
    k = 0;
    while (!bus.CmdReady && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.CmdReady) chk("accept_to", {127'd0, bus.CmdReady}, 128'd1);
    n.acc = cyc + 1;
    n.regs = pack_rf(sh);
    q.push_back(n);
    @(posedge clk);
    #1 bus.CmdValid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(q.size() == 0 && bus.CmdReady) && k < 100);
    if (q.size() != 0) chk("done_to", 128'(q.size()), 128'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.CmdValid = 1'b0;
    bus.CmdOp = 2'b00;
    bus.CmdSrc = 3'd0;
    bus.CmdDst = 3'd0;
    for (int i = 0; i < 8; i++) preload(i, 16'(16'h0100 * i + 16'h11));
    repeat (2) @(negedge clk);
    chk("rst_ready", {127'd0, bus.CmdReady}, 128'd1);
    chk("rst_done", {126'd0, bus.Done, bus.DoneErr}, 128'd0);
    chk("rst_sel", {120'd0, bus.RegSel, bus.ScrSel}, 128'hFF);
    chk("rst_fun", {125'd0, bus.FunSel}, 128'd2);
    chk("rst_out", {122'd0, bus.OutASel, bus.OutBSel}, 128'd0);
    chk("rst_rfi", {112'd0, bus.RfI}, 128'd0);
    chk("rst_perf", {112'd0, bus.PerfCount}, 128'd0);
    rst = 1'b0;

    preload(0, 16'h1234);
    issue(2'b00, 3'd0, 3'd2);
    @(negedge clk);
    chk("mv_regsel", {124'd0, bus.RegSel}, 128'b1101);
    chk("mv_scrsel", {124'd0, bus.ScrSel}, 128'hF);
    chk("mv_rfi", {112'd0, bus.RfI}, 128'h1234);
    chk("mv_outb", {125'd0, bus.OutBSel}, 128'd2);
    wait_idle();
    good++;

    preload(1, 16'hAAAA);
    preload(4, 16'h5555);
    issue(2'b01, 3'd1, 3'd4);
    wait_idle();
    chk("swap_s4", {112'd0, rf[7]}, 128'hAAAA);
    good++;

    issue(2'b01, 3'd3, 3'd7);
    @(negedge clk);
    chk("rej_sel", {120'd0, bus.RegSel, bus.ScrSel}, 128'hFF);
    wait_idle();

    preload(5, 16'hFFFF);
    issue(2'b11, 3'd0, 3'd5);
    wait_idle();
    chk("inc_wrap", {112'd0, rf[5]}, 128'h0);
    good++;

    issue(2'b10, 3'd3, 3'd0);
    @(negedge clk);
    chk("clr_busy1", {127'd0, bus.CmdReady}, 128'd0);
    @(negedge clk);
    chk("clr_busy2", {126'd0, bus.CmdReady, bus.Done}, 128'd1);
    @(negedge clk);
    chk("clr_ready", {127'd0, bus.CmdReady}, 128'd1);
    good++;
    wait_idle();

    issue(2'b00, 3'd6, 3'd6);
    issue(2'b01, 3'd2, 3'd2);
    issue(2'b01, 3'd0, 3'd6);
    issue(2'b11, 3'd0, 3'd0);
    for (int i = 0; i < 24; i++)
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
    wait_idle();

    preload(2, 16'hBEEF);
    preload(6, 16'hCAFE);
    issue(2'b01, 3'd2, 3'd6);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_sel", {120'd0, bus.RegSel, bus.ScrSel}, 128'hFF);
    chk("mid_ready", {126'd0, bus.CmdReady, bus.Done}, 128'd2);
    q.delete();
    for (int i = 0; i < 8; i++) sh[i] = rf[i];
    chk("mid_tmp", {112'd0, rf[7]}, 128'hBEEF);
    chk("mid_src", {112'd0, rf[2]}, 128'hBEEF);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_regs", pack_rf(rf), pack_rf(sh));
    chk("mid_perf", {112'd0, bus.PerfCount}, 128'd0);

    issue(2'b00, 3'd1, 3'd3);
    issue(2'b11, 3'd0, 3'd4);
    issue(2'b10, 3'd0, 3'd1);
    issue(2'b01, 3'd7, 3'd0);
    wait_idle();
`ifdef REGSEQ_PERF_EN
    chk("perf", {112'd0, bus.PerfCount}, 128'd3);
`else
    chk("perf", {112'd0, bus.PerfCount}, 128'd0);
`endif
    chk("one_en", 128'(bad_en), 128'd0);
    chk("q_empty", 128'(q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
